dff_write_arbiter: RTL
======================

Name: dff_write_arbiter

Overview:
Round-robin controller that shares one enabled D-register (WIDTH bits, per-bit enable-DFF datapath) among NREQ requesters. It selects one pending requester, drives the register's enable and data for exactly one cycle, and reads the register output back on the next cycle. It then acknowledges the requester and flags any readback mismatch. It sits between the requester logic and the enable/data inputs of the shared register in top-level integrations.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, register data width
IDW, 2, width of requester index; must equal clog2(NREQ)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester write request; level, held until gnt
wdata  input  NREQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH]; stable while req[i]=1
gnt  output  NREQ  one-hot acknowledge, one-cycle pulse, registered
reg_en  output  1  enable to shared register, registered
reg_d  output  WIDTH  data to shared register, registered
reg_q  input  WIDTH  shared register output (readback)
busy  output  1  high when state is not IDLE
err  output  1  sticky readback-mismatch flag
err_id  output  IDW  index of requester whose write last mismatched
err_clr  input  1  synchronous clear of err

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ptr=0, gnt=0, reg_en=0, reg_d=0, err=0, err_id=0, latched winner/data=0. Any in-flight write is abandoned with no gnt. The shared register may already have captured the data.
- FSM states:
  - IDLE, WRITE, VERIFY. All outputs are registered except busy, which is decoded from the state.
- IDLE:
  - If any req bit is set at the edge, the winner is the first set bit searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - At that edge: latch winner index and wdata slice; set reg_en=1 and reg_d=data; go to WRITE.
  - If no req is set: stay in IDLE with reg_en=0. reg_d holds its last value.
- WRITE (one cycle):
  - reg_en=1 for this cycle only; the shared register captures reg_d at the closing edge.
  - At the closing edge: reg_en→0, gnt[winner]→1, go to VERIFY.
- VERIFY (one cycle):
  - gnt[winner]=1 for this cycle only.
  - At the closing edge: compare reg_q to the latched data. On mismatch set err=1 and err_id=winner.
  - Also at that edge: gnt→0, ptr=(winner+1) mod NREQ, go to IDLE.
- Latency and throughput:
  - reg_en rises 1 cycle after req is sampled.
  - gnt pulses 2 cycles after req is sampled.
  - Minimum spacing between writes is 3 cycles (WRITE, VERIFY, IDLE).
- Requester rule: deassert req[i] or present new data on the edge that samples gnt[i]=1. A still-set req is treated as a new request at the next IDLE arbitration.
- A req dropped before it is sampled in IDLE is simply not served. Once a winner is latched, the write completes regardless of req changes.
- err handling:
  - err_clr=1 at an edge clears err; err_id is held.
  - A mismatch and err_clr at the same edge leave err=1 (set wins).
- Pointer wrap: winner=NREQ-1 gives ptr=0.
- Only one gnt bit is ever high; gnt is never high in IDLE or WRITE.

Test Plan:
1. Assert rst_n=0 mid-run → reg_en=0, reg_d=0, gnt=0, busy=0, err=0, err_id=0 immediately, without waiting for a clock edge.
2. req=0001 with wdata[7:0]=0xA5, reg_q modelled as an enable-DFF → reg_en=1 for exactly one cycle with reg_d=0xA5 one edge after sampling; gnt=0001 one cycle later; err stays 0.
3. req=1111 with data 0x11/0x22/0x33/0x44, each requester dropping req on its gnt → grants in order 0001, 0010, 0100, 1000 at 3-cycle spacing; reg_d sequence 0x11, 0x22, 0x33, 0x44.
4. After ptr=2, req[1] and req[3] held continuously → grant order 3, 1, 3, 1; no requester is served twice in a row.
5. Bench forces reg_q=0x00 while writing 0xFF from requester 2 → err=1, err_id=2 after VERIFY. A later err_clr pulse clears err. err_clr at the same edge as a new mismatch leaves err=1.
6. rst_n low during WRITE (reg_en=1) → reg_en=0 and no gnt issued. After release, a pending req is re-arbitrated from ptr=0.

Source files
------------

// File: rtl/dff_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_write_arbiter
// Purpose  : Round-robin write controller for one shared enabled D-register,
//            with registered grant and one-cycle readback verification.
// Revision : 1.0
// ============================================================================
module dff_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  reg_en,
  output logic [WIDTH-1:0]      reg_d,
  input  logic [WIDTH-1:0]      reg_q,
  output logic                  busy,
  output logic                  err,
  output logic [IDW-1:0]        err_id,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_win;
  logic [NREQ-1:0]  r_gnt;
  logic             r_en;
  logic [WIDTH-1:0] r_d;
  logic             r_err;
  logic [IDW-1:0]   r_err_id;

  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_idx;
  logic [IDW:0]     w_sum;
  logic [WIDTH-1:0] w_sel;
  logic [NREQ-1:0]  w_onehot;
  logic             w_mismatch;

  // Scan from the farthest offset down so the nearest set bit after ptr wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    w_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NREQ))
        w_sum = w_sum - (IDW+1)'(NREQ);
      w_idx = w_sum[IDW-1:0];
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_sel    = '0;
    w_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i))
        w_sel = wdata[i*WIDTH +: WIDTH];
      w_onehot[i] = (r_win == IDW'(i));
    end
  end

  // r_d doubles as the latched write data for the readback compare.
  assign w_mismatch = (r_state == S_VERIFY) && (reg_q != r_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_WRITE;
      S_WRITE:  w_next = S_VERIFY;
      S_VERIFY: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_win <= '0;
      r_gnt <= '0;
      r_en  <= 1'b0;
      r_d   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_gnt <= '0;
          r_en  <= w_any;
          if (w_any) begin
            r_win <= w_win;
            r_d   <= w_sel;
          end
        end
        S_WRITE: begin
          r_en  <= 1'b0;
          r_gnt <= w_onehot;
        end
        S_VERIFY: begin
          r_gnt <= '0;
          r_ptr <= (r_win == IDW'(NREQ - 1)) ? '0 : r_win + 1'b1;
        end
        default: begin
          r_gnt <= '0;
          r_en  <= 1'b0;
        end
      endcase
    end
  end

  // A mismatch at the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err    <= 1'b0;
      r_err_id <= '0;
    end else if (w_mismatch) begin
      r_err    <= 1'b1;
      r_err_id <= r_win;
    end else if (err_clr) begin
      r_err    <= 1'b0;
    end
  end

  assign gnt    = r_gnt;
  assign reg_en = r_en;
  assign reg_d  = r_d;
  assign busy   = (r_state != S_IDLE);
  assign err    = r_err;
  assign err_id = r_err_id;

endmodule
`default_nettype wire
